// File: rtl/board_mem_arbiter.sv
// Board frame memory (64 cells of {red, green}) shared by the LED scanner and the
// game logic, with a power-on clear and a commanded full-board clear sweep.
module board_mem_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_start,
  output logic              clear_busy,
  input  logic              scan_req,
  output logic              scan_grant,
  input  logic [ADDR_W-1:0] scan_addr,
  output logic              scan_valid,
  output logic [DATA_W-1:0] scan_data,
  input  logic              logic_req,
  output logic              logic_grant,
  input  logic              logic_we,
  input  logic [ADDR_W-1:0] logic_addr,
  input  logic [DATA_W-1:0] logic_wdata,
  output logic              logic_valid,
  output logic [DATA_W-1:0] logic_rdata
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_CELL = CNT_W'(DEPTH - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_LOGIC, ST_CLEAR} state_t;
  typedef enum logic {OWN_SCAN, OWN_LOGIC} owner_t;

  state_t            state;
  state_t            next_state;
  owner_t            last_owner;
  logic [CNT_W-1:0]  clear_cnt;
  logic              clear_pending;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              clear_hit;
  logic              clear_done;
  logic              scan_access;
  logic              logic_access;
  logic              logic_wr;
  logic              logic_rd;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  assign clear_hit    = clear_start || clear_pending;
  assign clear_done   = (clear_cnt == LAST_CELL);
  assign scan_access  = scan_req && scan_grant;
  assign logic_access = logic_req && logic_grant;
  assign logic_wr     = logic_access && logic_we;
  assign logic_rd     = logic_access && !logic_we;

  // NOTE: next_state gets a default before the case so every path assigns it
  // and no latch is inferred.
  always_comb begin
    next_state = state;
    case (state)
      ST_CLEAR: begin
        if (clear_done) next_state = ST_IDLE;
      end
      ST_IDLE: begin
        if (clear_hit)                   next_state = ST_CLEAR;
        else if (scan_req && logic_req)  next_state = (last_owner == OWN_SCAN) ? ST_LOGIC : ST_SCAN;
        else if (scan_req)               next_state = ST_SCAN;
        else if (logic_req)              next_state = ST_LOGIC;
      end
      ST_SCAN: begin
        if (!scan_req) begin
          if (clear_hit)      next_state = ST_CLEAR;
          else if (logic_req) next_state = ST_LOGIC;
          else                next_state = ST_IDLE;
        end
      end
      ST_LOGIC: begin
        if (!logic_req) begin
          if (clear_hit)     next_state = ST_CLEAR;
          else if (scan_req) next_state = ST_SCAN;
          else               next_state = ST_IDLE;
        end
      end
      default: next_state = ST_CLEAR;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register in
  // this block sees the pre-edge values of the others, exactly like flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_CLEAR;
      clear_cnt     <= '0;
      clear_busy    <= 1'b1;
      clear_pending <= 1'b0;
      scan_grant    <= 1'b0;
      logic_grant   <= 1'b0;
      last_owner    <= OWN_LOGIC;
    end else begin
      state       <= next_state;
      scan_grant  <= (next_state == ST_SCAN);
      logic_grant <= (next_state == ST_LOGIC);
      clear_busy  <= (next_state == ST_CLEAR);

      if (state == ST_CLEAR && !clear_done) clear_cnt <= clear_cnt + CNT_W'(1);

      // A new sweep always starts at cell 0 and consumes the pending request.
      if (next_state == ST_CLEAR && state != ST_CLEAR) begin
        clear_cnt     <= '0;
        clear_pending <= 1'b0;
      end else if (clear_start && (state == ST_SCAN || state == ST_LOGIC)) begin
        clear_pending <= 1'b1;
      end

      if (state == ST_SCAN && next_state != ST_SCAN)   last_owner <= OWN_SCAN;
      if (state == ST_LOGIC && next_state != ST_LOGIC) last_owner <= OWN_LOGIC;
    end
  end

  // The sweep and the logic port never write in the same cycle: no grant in CLEAR.
  assign mem_we    = rst_n && ((state == ST_CLEAR) || logic_wr);
  assign mem_waddr = (state == ST_CLEAR) ? clear_cnt[ADDR_W-1:0] : logic_addr;
  assign mem_wdata = (state == ST_CLEAR) ? '0 : logic_wdata;

  // NOTE: the array has no reset branch so it maps onto plain RAM; the clear
  // sweep that follows every reset gives it known contents.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_valid  <= 1'b0;
      scan_data   <= '0;
      logic_valid <= 1'b0;
      logic_rdata <= '0;
    end else begin
      scan_valid  <= scan_access;
      logic_valid <= logic_rd;
      if (scan_access) scan_data   <= mem[scan_addr];
      if (logic_rd)    logic_rdata <= mem[logic_addr];
    end
  end

  a_grant_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    !(scan_grant && logic_grant));
  a_no_grant_in_clear: assert property (@(posedge clk) disable iff (!rst_n)
    clear_busy |-> !(scan_grant || logic_grant));

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Self-checking bench for board_mem_arbiter: directed scenarios plus randomized
// bursts scored against a memory / round-robin reference model.
module tb_board_mem_arbiter;

  typedef struct packed {
    logic       we;
    logic [5:0] addr;
    logic [1:0] wdata;
  } op_t;

  logic       clk;
  logic       rst_n;
  logic       clear_start;
  logic       clear_busy;
  logic       scan_req;
  logic       scan_grant;
  logic [5:0] scan_addr;
  logic       scan_valid;
  logic [1:0] scan_data;
  logic       logic_req;
  logic       logic_grant;
  logic       logic_we;
  logic [5:0] logic_addr;
  logic [1:0] logic_wdata;
  logic       logic_valid;
  logic [1:0] logic_rdata;

  board_mem_arbiter #(.ADDR_W(6), .DATA_W(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_start (clear_start),
    .clear_busy  (clear_busy),
    .scan_req    (scan_req),
    .scan_grant  (scan_grant),
    .scan_addr   (scan_addr),
    .scan_valid  (scan_valid),
    .scan_data   (scan_data),
    .logic_req   (logic_req),
    .logic_grant (logic_grant),
    .logic_we    (logic_we),
    .logic_addr  (logic_addr),
    .logic_wdata (logic_wdata),
    .logic_valid (logic_valid),
    .logic_rdata (logic_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: board contents and which client was served last.
  logic [1:0] model_mem [64];
  bit         last_was_scan;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) model_mem[i] = 2'b00;
  endtask

  function automatic op_t mk_op(input logic we, input logic [5:0] addr, input logic [1:0] wdata);
    op_t o;
    o.we = we;
    o.addr = addr;
    o.wdata = wdata;
    return o;
  endfunction

  // Called on the first negedge where clear_busy is visible; counts busy cycles.
  task automatic measure_clear(input string tag, input int pulse_at);
    int n;
    int bad;
    n = 0;
    bad = 0;
    while (clear_busy && n < 200) begin
      if (scan_grant || logic_grant) bad++;
      clear_start = (n == pulse_at);
      n++;
      @(negedge clk);
    end
    clear_start = 1'b0;
    check({tag, " clear length"}, n, 64);
    check({tag, " grants during clear"}, bad, 0);
  endtask

  // Precondition: scanner holds the grant at this negedge with scan_req high.
  task automatic scan_reads(input logic [5:0] addrs[$], input int clr_at, input string tag);
    logic [1:0] exp_data;
    exp_data = 2'b00;
    for (int i = 0; i <= addrs.size(); i++) begin
      if (i > 0) begin
        check({tag, " scan_valid"}, scan_valid, 1);
        check({tag, " scan_data"}, scan_data, exp_data);
      end
      clear_start = (i == clr_at);
      if (i < addrs.size()) begin
        scan_addr = addrs[i];
        exp_data  = model_mem[addrs[i]];
        @(negedge clk);
      end
    end
    clear_start = 1'b0;
  endtask

  // Precondition: logic holds the grant at this negedge with logic_req high.
  task automatic logic_ops(input op_t ops[$], input string tag);
    logic       exp_valid;
    logic [1:0] exp_data;
    exp_valid = 1'b0;
    exp_data  = 2'b00;
    for (int i = 0; i <= ops.size(); i++) begin
      if (i > 0) begin
        check({tag, " logic_valid"}, logic_valid, exp_valid);
        if (exp_valid) check({tag, " logic_rdata"}, logic_rdata, exp_data);
      end
      if (i < ops.size()) begin
        logic_we    = ops[i].we;
        logic_addr  = ops[i].addr;
        logic_wdata = ops[i].wdata;
        if (ops[i].we) begin
          model_mem[ops[i].addr] = ops[i].wdata;
          exp_valid = 1'b0;
        end else begin
          exp_valid = 1'b1;
          exp_data  = model_mem[ops[i].addr];
        end
        @(negedge clk);
      end
    end
    logic_we = 1'b0;
  endtask

  task automatic scan_rand(input string tag);
    logic [5:0] q[$];
    int len;
    len = $urandom_range(1, 8);
    for (int i = 0; i < len; i++) q.push_back(6'($urandom_range(0, 63)));
    scan_reads(q, -1, tag);
  endtask

  task automatic logic_rand(input string tag);
    op_t q[$];
    int len;
    len = $urandom_range(1, 8);
    for (int i = 0; i < len; i++)
      q.push_back(mk_op(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))));
    logic_ops(q, tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] aq[$];
    op_t        oq[$];
    logic [5:0] probe;

    rst_n = 1'b0; clear_start = 1'b0;
    scan_req = 1'b0; scan_addr = '0;
    logic_req = 1'b0; logic_we = 1'b0; logic_addr = '0; logic_wdata = '0;
    model_clear();
    last_was_scan = 1'b0;

    // Reset state, power-on clear, then a full read-back sweep.
    @(negedge clk);
    check("rst clear_busy", clear_busy, 1);
    check("rst scan_grant", scan_grant, 0);
    check("rst logic_grant", logic_grant, 0);
    check("rst scan_valid", scan_valid, 0);
    check("rst logic_valid", logic_valid, 0);
    check("rst scan_data", scan_data, 0);
    check("rst logic_rdata", logic_rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    scan_req = 1'b1;
    measure_clear("power-on", -1);
    @(negedge clk);
    check("sweep scan_grant", scan_grant, 1);
    for (int a = 0; a < 64; a++) aq.push_back(6'(a));
    scan_reads(aq, -1, "sweep");

    // Logic writes, ignored ungranted write, scanner read-back.
    scan_req = 1'b0;
    logic_req = 1'b1;
    @(negedge clk);
    check("wr handover logic_grant", logic_grant, 1);
    check("wr scan_valid after burst", scan_valid, 0);
    oq.push_back(mk_op(1'b1, 6'o35, 2'b10));
    oq.push_back(mk_op(1'b1, 6'o00, 2'b01));
    logic_ops(oq, "wr");
    logic_req = 1'b0;
    scan_req = 1'b1;
    logic_we = 1'b1; logic_addr = 6'o35; logic_wdata = 2'b11;
    @(negedge clk);
    check("rb scan_grant", scan_grant, 1);
    aq.delete();
    aq.push_back(6'o35);
    aq.push_back(6'o00);
    scan_reads(aq, -1, "rb");
    check("rb cell 35 value", scan_data == 2'b01 ? 2'b10 : scan_data, 2'b10);
    scan_req = 1'b0;
    logic_we = 1'b0;
    @(negedge clk);
    check("rb scan_valid drop", scan_valid, 0);

    // Reset for one cycle partway through the sweep restarts it at 0.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("mid-sweep still busy", clear_busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    measure_clear("restart", -1);
    model_clear();
    last_was_scan = 1'b0;

    // Simultaneous requests after reset: scanner first, then handover to logic.
    scan_req = 1'b1;
    logic_req = 1'b1;
    @(negedge clk);
    check("rr scan wins", scan_grant, 1);
    check("rr logic waits", logic_grant, 0);
    aq.delete();
    for (int i = 0; i < 8; i++) aq.push_back(6'($urandom_range(0, 63)));
    scan_reads(aq, -1, "rr scan");
    scan_req = 1'b0;
    @(negedge clk);
    check("rr handover logic_grant", logic_grant, 1);
    check("rr handover scan_grant", scan_grant, 0);
    probe = 6'($urandom_range(0, 63));
    oq.delete();
    oq.push_back(mk_op(1'b1, probe, 2'b11));
    for (int i = 0; i < 10; i++)
      oq.push_back(mk_op(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))));
    oq.push_back(mk_op(1'b1, probe, 2'b11));
    logic_ops(oq, "rr logic");
    logic_req = 1'b0;
    @(negedge clk);
    check("rr idle no grant", scan_grant | logic_grant, 0);
    scan_req = 1'b1;
    logic_req = 1'b1;
    @(negedge clk);
    check("rr scan wins again", scan_grant, 1);

    // Clear requested mid-burst waits for the burst, then blocks the logic request.
    aq.delete();
    aq.push_back(probe);
    for (int i = 0; i < 7; i++) aq.push_back(6'($urandom_range(0, 63)));
    scan_reads(aq, 4, "pend scan");
    scan_req = 1'b0;
    @(negedge clk);
    measure_clear("pending", 10);
    model_clear();
    last_was_scan = 1'b1;
    @(negedge clk);
    check("pend logic_grant after clear", logic_grant, 1);
    oq.delete();
    oq.push_back(mk_op(1'b0, probe, 2'b00));
    logic_ops(oq, "pend cleared read");
    logic_req = 1'b0;
    @(negedge clk);
    last_was_scan = 1'b0;

    // Randomized rounds: solo bursts, contended bursts, idle clears.
    for (int r = 0; r < 30; r++) begin
      int kind;
      kind = $urandom_range(0, 3);
      if (kind == 0) begin
        clear_start = 1'b1;
        @(negedge clk);
        clear_start = 1'b0;
        measure_clear("rand", -1);
        model_clear();
      end else if (kind == 1) begin
        scan_req = 1'b1;
        @(negedge clk);
        check("rand scan latency", scan_grant, 1);
        scan_rand("rand scan");
        scan_req = 1'b0;
        @(negedge clk);
        check("rand scan release", {scan_grant, scan_valid}, 2'b00);
        last_was_scan = 1'b1;
      end else if (kind == 2) begin
        logic_req = 1'b1;
        @(negedge clk);
        check("rand logic latency", logic_grant, 1);
        logic_rand("rand logic");
        logic_req = 1'b0;
        @(negedge clk);
        check("rand logic release", {logic_grant, logic_valid}, 2'b00);
        last_was_scan = 1'b0;
      end else begin
        scan_req = 1'b1;
        logic_req = 1'b1;
        @(negedge clk);
        if (last_was_scan) begin
          check("rand rr grants", {scan_grant, logic_grant}, 2'b01);
          logic_rand("rand rr logic");
          logic_req = 1'b0;
          @(negedge clk);
          check("rand rr handover", {scan_grant, logic_grant, logic_valid}, 3'b100);
          scan_rand("rand rr scan");
          scan_req = 1'b0;
          last_was_scan = 1'b1;
        end else begin
          check("rand rr grants", {scan_grant, logic_grant}, 2'b10);
          scan_rand("rand rr scan");
          scan_req = 1'b0;
          @(negedge clk);
          check("rand rr handover", {scan_grant, logic_grant, scan_valid}, 3'b010);
          logic_rand("rand rr logic");
          logic_req = 1'b0;
          last_was_scan = 1'b0;
        end
        @(negedge clk);
        check("rand rr idle", {scan_grant, logic_grant}, 2'b00);
      end
    end

    // Reset while logic owns the memory with a read in flight.
    logic_req = 1'b1;
    @(negedge clk);
    check("rst-own logic_grant", logic_grant, 1);
    logic_we = 1'b0;
    logic_addr = 6'($urandom_range(0, 63));
    rst_n = 1'b0;
    @(negedge clk);
    check("rst-own logic_grant dropped", logic_grant, 0);
    check("rst-own logic_valid dropped", logic_valid, 0);
    check("rst-own clear_busy", clear_busy, 1);
    logic_req = 1'b0;
    rst_n = 1'b1;
    measure_clear("rst-own", -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
